// File: rtl/vector_mem_job_sequencer.sv
// vector_mem_job_sequencer: queues vector-memory job descriptors, validates them and sequences one job at a time
module vector_mem_job_sequencer #(
    parameter int MATRIXSIZE_W = 24,
    parameter int MEM_DEPTH    = 4096,
    parameter int QDEPTH       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_desc_valid,
    output logic                    o_desc_ready,
    input  logic [MATRIXSIZE_W-1:0] i_desc_dim1,
    input  logic [MATRIXSIZE_W-1:0] i_desc_dim2,
    input  logic [MATRIXSIZE_W-1:0] i_desc_bw,
    input  logic                    i_src_tvalid,
    output logic                    o_src_tready,
    input  logic                    i_src_tlast,
    output logic                    o_mem_in_tvalid,
    input  logic                    i_mem_in_tready,
    output logic                    o_mem_in_tlast,
    input  logic                    i_mem_out_hs,
    input  logic                    i_mem_out_tlast,
    output logic [MATRIXSIZE_W-1:0] o_dim1,
    output logic [MATRIXSIZE_W-1:0] o_dim2,
    output logic [MATRIXSIZE_W-1:0] o_blocks,
    output logic [MATRIXSIZE_W-1:0] o_block_width,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [2:0]              o_err_code
);
    localparam int W  = MATRIXSIZE_W;
    localparam int AW = $clog2(QDEPTH);
    localparam logic [W-1:0]   MAX_D2 = W'(MEM_DEPTH);
    localparam logic [W-1:0]   ONE    = W'(1);
    localparam logic [2*W-1:0] ONE2   = (2*W)'(1);
    localparam logic [AW:0]    ONE_P  = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_WRITE, S_READ, S_DONE} state_t;

    logic [3*W-1:0] r_fifo [QDEPTH];
    logic [AW:0]    r_wr, r_rd;
    state_t         r_state, w_nxt;
    logic [W-1:0]   r_d1, r_d2, r_bw, r_rem, r_blk, r_in_cnt;
    logic [W-1:0]   r_cfg_d1, r_cfg_d2, r_cfg_blk, r_cfg_bw;
    logic [2*W-1:0] r_out_cnt, r_total;
    logic           r_first;
    logic           w_full, w_empty, w_push, w_pop, w_in_hs, w_err;
    logic [2:0]     w_code;
    logic [W-1:0]   w_rem_sub, w_blk_inc;

    assign w_empty         = r_wr == r_rd;
    assign w_full          = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_desc_ready    = !w_full;
    assign w_push          = i_desc_valid && !w_full;
    assign w_pop           = (r_state == S_IDLE) && !w_empty;
    assign o_src_tready    = i_mem_in_tready && (r_state == S_WRITE);
    assign o_mem_in_tvalid = i_src_tvalid && (r_state == S_WRITE);
    assign o_mem_in_tlast  = i_src_tlast;
    assign w_in_hs         = i_src_tvalid && o_src_tready;
    assign w_rem_sub       = r_rem - r_bw;
    assign w_blk_inc       = &r_blk ? r_blk : r_blk + ONE;
    assign o_busy          = r_state != S_IDLE;
    assign o_done          = r_state == S_DONE;
    assign o_err           = w_err;
    assign o_err_code      = w_code;
    assign o_dim1          = r_cfg_d1;
    assign o_dim2          = r_cfg_d2;
    assign o_blocks        = r_cfg_blk;
    assign o_block_width   = r_cfg_bw;

    // descriptor storage; only the pointers need resetting
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr[AW-1:0]] <= {i_desc_dim1, i_desc_dim2, i_desc_bw};
    end

    // next state and error pulses; division ends when the next remainder drops below BW
    always_comb begin
        w_nxt  = r_state;
        w_err  = 1'b0;
        w_code = 3'd0;
        case (r_state)
            S_IDLE:  w_nxt = w_empty ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (r_first) begin
                    if (r_d1 == '0 || r_d2 == '0 || r_bw == '0) begin
                        w_err  = 1'b1;
                        w_code = 3'd1;
                        w_nxt  = S_IDLE;
                    end else if (r_d2 > MAX_D2) begin
                        w_err  = 1'b1;
                        w_code = 3'd2;
                        w_nxt  = S_IDLE;
                    end else if (r_d2 < r_bw) begin
                        w_err  = 1'b1;
                        w_code = 3'd3;
                        w_nxt  = S_IDLE;
                    end
                end else if (w_rem_sub < r_bw) begin
                    w_err  = w_rem_sub != '0;
                    w_code = w_err ? 3'd3 : 3'd0;
                    w_nxt  = w_err ? S_IDLE : S_LOAD;
                end
            end
            S_LOAD:  w_nxt = S_WRITE;
            S_WRITE: begin
                if (w_in_hs && i_src_tlast) begin
                    w_err  = ({1'b0, r_in_cnt} + (W+1)'(1)) != {1'b0, r_d2};
                    w_code = w_err ? 3'd4 : 3'd0;
                    w_nxt  = S_READ;
                end
            end
            S_READ: begin
                if (i_mem_out_hs && i_mem_out_tlast) begin
                    w_err  = ({1'b0, r_out_cnt} + (2*W+1)'(1)) != {1'b0, r_total};
                    w_code = w_err ? 3'd5 : 3'd0;
                    w_nxt  = S_DONE;
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // state, FIFO pointers, divider, beat counters and the job configuration
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_wr      <= '0;
            r_rd      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_bw      <= '0;
            r_rem     <= '0;
            r_blk     <= '0;
            r_first   <= 1'b0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_total   <= '0;
            r_cfg_d1  <= '0;
            r_cfg_d2  <= '0;
            r_cfg_blk <= '0;
            r_cfg_bw  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_push) r_wr <= r_wr + ONE_P;
            if (w_pop) begin
                {r_d1, r_d2, r_bw} <= r_fifo[r_rd[AW-1:0]];
                r_rd    <= r_rd + ONE_P;
                r_first <= 1'b1;
            end
            if (r_state == S_CHECK) begin
                r_first <= 1'b0;
                r_rem   <= r_first ? r_d2 : w_rem_sub;
                r_blk   <= r_first ? '0 : w_blk_inc;
            end
            if (w_nxt == S_LOAD) begin
                r_cfg_d1  <= r_d1;
                r_cfg_d2  <= r_d2;
                r_cfg_blk <= w_blk_inc;
                r_cfg_bw  <= r_bw;
                r_total   <= (2*W)'(r_d1) * (2*W)'(r_d2);
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end
            if (r_state == S_WRITE && w_in_hs && !(&r_in_cnt)) r_in_cnt <= r_in_cnt + ONE;
            if (r_state == S_READ && i_mem_out_hs && !(&r_out_cnt)) r_out_cnt <= r_out_cnt + ONE2;
        end
    end
endmodule

// File: tb/tb_vector_mem_job_sequencer.sv
// tb_vector_mem_job_sequencer: scoreboard bench with stream driver and job-level reference model
module tb_vector_mem_job_sequencer;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_desc_valid;
    logic         o_desc_ready;
    logic [W-1:0] i_desc_dim1, i_desc_dim2, i_desc_bw;
    logic         i_src_tvalid, o_src_tready, i_src_tlast;
    logic         o_mem_in_tvalid, i_mem_in_tready, o_mem_in_tlast;
    logic         i_mem_out_hs, i_mem_out_tlast;
    logic [W-1:0] o_dim1, o_dim2, o_blocks, o_block_width;
    logic         o_busy, o_done, o_err;
    logic [2:0]   o_err_code;

    always #5 clk = ~clk;

    vector_mem_job_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
        .i_desc_dim1(i_desc_dim1), .i_desc_dim2(i_desc_dim2), .i_desc_bw(i_desc_bw),
        .i_src_tvalid(i_src_tvalid), .o_src_tready(o_src_tready), .i_src_tlast(i_src_tlast),
        .o_mem_in_tvalid(o_mem_in_tvalid), .i_mem_in_tready(i_mem_in_tready), .o_mem_in_tlast(o_mem_in_tlast),
        .i_mem_out_hs(i_mem_out_hs), .i_mem_out_tlast(i_mem_out_tlast),
        .o_dim1(o_dim1), .o_dim2(o_dim2), .o_blocks(o_blocks), .o_block_width(o_block_width),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code)
    );

    typedef struct {
        bit           is_err;
        int           code;
        int           chk;
        logic [W-1:0] d1, d2, blk, bw;
    } exp_t;

    typedef struct {
        int nin;
        int nout;
        bit with_last;
    } job_t;

    exp_t         sbq[$];
    job_t         jq[$];
    int           checks = 0;
    int           failures = 0;
    int           busy_run = 0;
    logic [W-1:0] m_d1 = '0, m_d2 = '0, m_blk = '0, m_bw = '0;

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(bit e, int code, int chk);
        exp_t x;
        x.is_err = e;
        x.code   = code;
        x.chk    = chk;
        x.d1     = m_d1;
        x.d2     = m_d2;
        x.blk    = m_blk;
        x.bw     = m_bw;
        return x;
    endfunction

    // job-level model: outcome of a descriptor plus the beat counts the memory side will see
    task automatic model(int d1, int d2, int bw, int nin, int nout);
        if (d1 == 0 || d2 == 0 || bw == 0) sbq.push_back(mk(1, 1, 1));
        else if (d2 > 4096) sbq.push_back(mk(1, 2, 1));
        else if (d2 % bw != 0) sbq.push_back(mk(1, 3, 1 + d2 / bw));
        else begin
            m_d1  = W'(d1);
            m_d2  = W'(d2);
            m_bw  = W'(bw);
            m_blk = W'(d2 / bw);
            jq.push_back('{nin, nout, 1'b1});
            if (nin != d2) sbq.push_back(mk(1, 4, 0));
            if (nout != d1 * d2) sbq.push_back(mk(1, 5, 0));
            sbq.push_back(mk(0, 0, 0));
        end
    endtask

    // called at a negedge; returns at the negedge after the descriptor is accepted
    task automatic push(int d1, int d2, int bw, int nin, int nout, bit track);
        int t = 0;
        i_desc_valid = 1'b1;
        i_desc_dim1  = W'(d1);
        i_desc_dim2  = W'(d2);
        i_desc_bw    = W'(bw);
        while (!o_desc_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=not_ready required=ready");
        end
        @(negedge clk);
        i_desc_valid = 1'b0;
        if (track) model(d1, d2, bw, nin, nout);
    endtask

    task automatic drive(int nin, int nout, bit with_last);
        int i = 0;
        int t = 0;
        bit hs;
        while (i < nin && t < 4000) begin
            @(negedge clk);
            t++;
            i_mem_in_tready = ($urandom_range(0, 3) != 0);
            i_src_tvalid    = ($urandom_range(0, 3) != 0);
            i_src_tlast     = (i == nin - 1);
            #1;
            if (i_src_tvalid && o_src_tready) i++;
        end
        i = 0;
        while (i < nout && t < 4000) begin
            @(negedge clk);
            t++;
            i_src_tvalid    = 1'b0;
            i_src_tlast     = 1'b0;
            hs              = ($urandom_range(0, 3) != 0);
            i_mem_out_hs    = hs;
            i_mem_out_tlast = with_last && hs && (i == nout - 1);
            if (hs) i++;
        end
        @(negedge clk);
        i_src_tvalid    = 1'b0;
        i_src_tlast     = 1'b0;
        i_mem_out_hs    = 1'b0;
        i_mem_out_tlast = 1'b0;
        if (t >= 4000) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout actual=stalled required=stream_accepted");
        end
    endtask

    // stream driver: plays the source and the memory read side for each accepted job in order
    initial begin
        forever begin
            @(negedge clk);
            if (jq.size() != 0) begin
                drive(jq[0].nin, jq[0].nout, jq[0].with_last);
                void'(jq.pop_front());
            end
        end
    end

    // monitor: every done/err pulse pops and checks the next expected event
    always @(negedge clk) begin
        exp_t e;
        busy_run = (o_busy === 1'b1) ? busy_run + 1 : 0;
        if (o_done === 1'b1 && o_err === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_err_overlap actual=both required=exclusive");
        end else if (o_done === 1'b1 || o_err === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=done%0b_err%0b_code%0d required=none", o_done, o_err, o_err_code);
            end else begin
                e = sbq.pop_front();
                if (o_err !== e.is_err || (e.is_err && o_err_code !== 3'(e.code)) ||
                    o_dim1 !== e.d1 || o_dim2 !== e.d2 || o_blocks !== e.blk || o_block_width !== e.bw ||
                    (e.chk != 0 && busy_run != e.chk)) begin
                    failures++;
                    $display("FAIL job_event actual=err%0b code%0d cfg %0d/%0d/%0d/%0d busy%0d required=err%0b code%0d cfg %0d/%0d/%0d/%0d busy%0d",
                             o_err, o_err_code, o_dim1, o_dim2, o_blocks, o_block_width, busy_run,
                             e.is_err, e.code, e.d1, e.d2, e.blk, e.bw, e.chk);
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || jq.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst = 1'b0;
        i_desc_valid = 1'b0;
        i_desc_dim1 = '0;
        i_desc_dim2 = '0;
        i_desc_bw = '0;
        i_src_tvalid = 1'b0;
        i_src_tlast = 1'b0;
        i_mem_in_tready = 1'b0;
        i_mem_out_hs = 1'b0;
        i_mem_out_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(o_busy), 128'(0));
        check("reset_pulses", 128'({o_done, o_err}), 128'(0));
        check("reset_cfg", 128'({o_dim1, o_dim2, o_blocks, o_block_width}), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        check("reset_desc_ready", 128'(o_desc_ready), 128'(1));

        push(4, 8, 4, 8, 32, 1);
        push(2, 6, 4, 0, 0, 1);
        push(4, 8, 4, 8, 32, 1);
        push(1, 5000, 8, 0, 0, 1);
        push(0, 8, 8, 0, 0, 1);
        push(2, 8, 8, 6, 16, 1);
        drain();

        push(4, 8, 4, 8, 32, 1);
        for (int k = 0; k < 4; k++) push(1, 4, 2, 4, 4, 1);
        check("fifo_full_ready", 128'(o_desc_ready), 128'(0));
        check("fifo_full_busy", 128'(o_busy), 128'(1));
        drain();

        for (int k = 0; k < 12; k++) begin
            int d1, d2, bw, nin, nout, sel;
            d1  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            bw  = $urandom_range(1, 8);
            d2  = bw * int'($urandom_range(1, 6));
            sel = $urandom_range(0, 9);
            if (sel == 0) d2 = 4096 + int'($urandom_range(1, 50));
            else if (sel == 1 && bw > 1) d2 = d2 + int'($urandom_range(1, bw - 1));
            nin  = ($urandom_range(0, 5) == 0) ? d2 + 1 : d2;
            nout = ($urandom_range(0, 5) == 0) ? d1 * d2 + 1 : d1 * d2;
            push(d1, d2, bw, nin, nout, 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        drain();

        push(4, 8, 4, 8, 10, 0);
        push(2, 4, 2, 0, 0, 0);
        push(1, 2, 2, 0, 0, 0);
        jq.push_back('{8, 10, 1'b0});
        t = 0;
        while (jq.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("mid_read_busy", 128'(o_busy), 128'(1));
        rst = 1'b0;
        @(negedge clk);
        check("midjob_reset_busy", 128'(o_busy), 128'(0));
        check("midjob_reset_cfg", 128'({o_dim1, o_dim2, o_blocks, o_block_width}), 128'(0));
        check("midjob_reset_pulses", 128'({o_done, o_err}), 128'(0));
        rst = 1'b1;
        m_d1 = '0;
        m_d2 = '0;
        m_blk = '0;
        m_bw = '0;
        repeat (4) @(negedge clk);
        check("post_reset_fifo_empty", 128'(o_busy), 128'(0));
        check("post_reset_desc_ready", 128'(o_desc_ready), 128'(1));
        push(3, 4, 2, 4, 12, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
